// File: rtl/sw_io_pkg.sv
// sw_io_pkg: register offsets and default debounce length for the switch input peripheral
package sw_io_pkg;
    typedef enum logic [1:0] {
        SW_REG_DATA  = 2'd0,
        SW_REG_EDGE  = 2'd1,
        SW_REG_IRQEN = 2'd2,
        SW_REG_RAW   = 2'd3
    } sw_reg_e;
    localparam int DB_CYCLES_DEF = 200000;
endpackage

// File: rtl/switch_debounce_io_if.sv
// switch_debounce_io_if: CPU-side MMIO bus of the switch peripheral
interface switch_debounce_io_if;
    logic [31:0] addr_to_sw;
    logic        re;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata_from_sw;
    logic        irq;
    modport master(output addr_to_sw, re, we, wdata, input rdata_from_sw, irq);
    modport slave(input addr_to_sw, re, we, wdata, output rdata_from_sw, irq);
endinterface

// File: rtl/sw_debounce_bit.sv
// sw_debounce_bit: 2-flop synchroniser, hold counter and stable level for one switch pin
module sw_debounce_bit
    import sw_io_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic sync,
    output logic stable,
    output logic chg
);
    logic             meta;
    logic [CNT_W-1:0] cnt;
    logic             hit;
    assign hit = cnt == CNT_W'(DB_CYCLES - 1);
    assign chg = (sync != stable) && hit;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            meta <= pin;
            sync <= meta;
            if (sync == stable) cnt <= '0;
            else if (hit) begin
                stable <= sync;
                cnt    <= '0;
            end else cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/switch_debounce_io.sv
// switch_debounce_io: debounced switch inputs with W1C edge flags, maskable irq and registered read port
module switch_debounce_io
    import sw_io_pkg::*;
#(
    parameter int N_SW      = 24,
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    switch_debounce_io_if.slave  bus,
    input  logic [N_SW-1:0]      sw
);
    logic [N_SW-1:0] sync, stable, chg, edge_flag, irq_en, clr, edge_nxt;
    logic [31:0]     rd_val;
    sw_reg_e         sel;
    logic            unused_bus;
    for (genvar i = 0; i < N_SW; i++) begin : g_bit
        sw_debounce_bit #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_bit (
            .clk(clk), .rst(rst), .pin(sw[i]),
            .sync(sync[i]), .stable(stable[i]), .chg(chg[i])
        );
    end
    assign sel        = sw_reg_e'(bus.addr_to_sw[3:2]);
    assign unused_bus = ^{bus.addr_to_sw[31:4], bus.addr_to_sw[1:0], bus.wdata};
    // a new edge in the same cycle as its W1C clear keeps the flag set
    always_comb begin
        rd_val   = sel == SW_REG_DATA  ? 32'(stable)    :
                   sel == SW_REG_EDGE  ? 32'(edge_flag) :
                   sel == SW_REG_IRQEN ? 32'(irq_en)    : 32'(sync);
        clr      = (bus.we && sel == SW_REG_EDGE) ? bus.wdata[N_SW-1:0] : '0;
        edge_nxt = (edge_flag & ~clr) | chg;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_flag         <= '0;
            irq_en            <= '0;
            bus.rdata_from_sw <= '0;
            bus.irq           <= 1'b0;
        end else begin
            edge_flag <= edge_nxt;
            if (bus.we && sel == SW_REG_IRQEN) irq_en <= bus.wdata[N_SW-1:0];
            if (bus.re) bus.rdata_from_sw <= rd_val;
            bus.irq <= |(edge_flag & irq_en);
        end
    end
endmodule

// File: tb/tb_switch_debounce_io.sv
// tb_switch_debounce_io: table, directed corner cases and random traffic against a history-window model
module tb_switch_debounce_io;
    import sw_io_pkg::*;
    localparam int N = 24;
    localparam int DB = 4;
    localparam logic [31:0] A_DATA = 32'h0, A_EDGE = 32'h4, A_EN = 32'h8, A_RAW = 32'hC;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  sw  = '0;
    switch_debounce_io_if bus();
    switch_debounce_io #(.N_SW(N), .DB_CYCLES(DB), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .bus(bus), .sw(sw)
    );
    always #5 clk = ~clk;
    int errors = 0;
    int checks = 0;
    // model: a level is accepted once the synchronised pin has shown it for DB sampled cycles
    logic [N-1:0] hist [DB+1];
    logic [N-1:0] m_stable, m_edge, m_en;
    logic [31:0]  m_rdata;
    logic         m_irq;
    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [9];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic m_reset();
        for (int j = 0; j <= DB; j++) hist[j] = '0;
        m_stable = '0;
        m_edge   = '0;
        m_en     = '0;
        m_rdata  = '0;
        m_irq    = 1'b0;
    endtask
    task automatic m_step();
        logic [N-1:0] acc, rd, clr;
        logic [1:0]   sel;
        sel = bus.addr_to_sw[3:2];
        acc = '1;
        for (int j = 1; j <= DB; j++) acc &= hist[j] ^ m_stable;
        rd = sel == 2'd0 ? m_stable : sel == 2'd1 ? m_edge : sel == 2'd2 ? m_en : hist[1];
        clr = (bus.we && sel == 2'd1) ? bus.wdata[N-1:0] : '0;
        if (bus.re) m_rdata = 32'(rd);
        m_irq  = |(m_edge & m_en);
        m_edge = (m_edge & ~clr) | acc;
        if (bus.we && sel == 2'd2) m_en = bus.wdata[N-1:0];
        m_stable ^= acc;
        for (int j = DB; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = sw;
    endtask
    task automatic cyc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.re = r;
        bus.we = w;
        bus.addr_to_sw = a;
        bus.wdata = d;
        @(posedge clk);
        if (rst) m_reset();
        else m_step();
        @(negedge clk);
        chk("model_rdata", bus.rdata_from_sw, m_rdata);
        chk("model_irq", {31'b0, bus.irq}, {31'b0, m_irq});
    endtask
    task automatic rd(input logic [31:0] a);
        cyc(1'b1, 1'b0, a, 32'h0);
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, a, d);
    endtask
    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 32'h0);
    endtask
    initial begin
        logic seen;
        tbl[0] = '{1'b0, 1'b1, A_EN,   32'hFFFF_FFFF, 32'h0000_0000};
        tbl[1] = '{1'b1, 1'b0, A_EN,   32'h0,         32'h00FF_FFFF};
        tbl[2] = '{1'b1, 1'b1, A_DATA, 32'h1234_5678, 32'h0000_0000};
        tbl[3] = '{1'b1, 1'b0, A_RAW,  32'h0,         32'h0000_0000};
        tbl[4] = '{1'b1, 1'b1, A_EN,   32'h0000_00A5, 32'h00FF_FFFF};
        tbl[5] = '{1'b1, 1'b0, A_EN,   32'h0,         32'h0000_00A5};
        tbl[6] = '{1'b0, 1'b0, A_EN,   32'h0,         32'h0000_00A5};
        tbl[7] = '{1'b1, 1'b0, A_EDGE, 32'h0,         32'h0000_0000};
        tbl[8] = '{1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0,  32'h0000_00A5};
        bus.re = 1'b0;
        bus.we = 1'b0;
        bus.addr_to_sw = '0;
        bus.wdata = '0;
        m_reset();
        idle();
        idle();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d);
            chk($sformatf("tbl%0d_rdata", i), bus.rdata_from_sw, tbl[i].exp);
            chk($sformatf("tbl%0d_irq", i), {31'b0, bus.irq}, 32'h0);
        end
        // asynchronous reset in the middle of the low phase
        sw = '1;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rdata", bus.rdata_from_sw, 32'h0);
        chk("async_rst_irq", {31'b0, bus.irq}, 32'h0);
        m_reset();
        idle();
        idle();
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            rd(A_DATA);
            if (k == 1) chk("post_rst_data", bus.rdata_from_sw, 32'h0);
            if (k == 6) chk("requal_k6", bus.rdata_from_sw, 32'h0);
            if (k == 7) chk("requal_k7", bus.rdata_from_sw, 32'h00FF_FFFF);
        end
        sw = '0;
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
        // debounce latency of bit 0
        sw = 24'h1;
        for (int k = 1; k <= 7; k++) begin
            rd(A_DATA);
            if (k == 6) chk("deb_k6", bus.rdata_from_sw, 32'h0);
            if (k == 7) chk("deb_k7", bus.rdata_from_sw, 32'h1);
        end
        rd(A_EDGE);
        chk("deb_edge", bus.rdata_from_sw, 32'h1);
        // 3-cycle glitch on bit 5
        seen = 1'b0;
        sw = 24'h21;
        for (int k = 0; k < 3; k++) begin rd(A_RAW); seen |= bus.rdata_from_sw[5]; end
        sw = 24'h1;
        for (int k = 0; k < 3; k++) begin rd(A_RAW); seen |= bus.rdata_from_sw[5]; end
        chk("glitch_raw", {31'b0, seen}, 32'h1);
        for (int k = 0; k < 6; k++) idle();
        rd(A_DATA);
        chk("glitch_data", bus.rdata_from_sw, 32'h1);
        rd(A_EDGE);
        chk("glitch_edge", bus.rdata_from_sw, 32'h1);
        // irq on qualification, drop after W1C
        wr(A_EDGE, 32'hFFFF_FFFF);
        sw = 24'h0;
        for (int k = 0; k < 8; k++) idle();
        wr(A_EDGE, 32'hFFFF_FFFF);
        wr(A_EN, 32'h1);
        idle();
        chk("irq_idle", {31'b0, bus.irq}, 32'h0);
        sw = 24'h1;
        for (int k = 1; k <= 7; k++) begin
            idle();
            if (k == 6) chk("irq_k6", {31'b0, bus.irq}, 32'h0);
            if (k == 7) chk("irq_k7", {31'b0, bus.irq}, 32'h1);
        end
        wr(A_EDGE, 32'h1);
        chk("irq_clr_same", {31'b0, bus.irq}, 32'h1);
        idle();
        chk("irq_clr_next", {31'b0, bus.irq}, 32'h0);
        // W1C of bit 3 on the cycle it qualifies
        sw = 24'h9;
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) wr(A_EDGE, 32'h8);
            else idle();
        end
        rd(A_EDGE);
        chk("collision_edge", bus.rdata_from_sw, 32'h8);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 11) == 0) sw ^= N'(1) << $urandom_range(0, N - 1);
            cyc(1'($urandom), $urandom_range(0, 3) == 0, $urandom, $urandom);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
